// File: rtl/id_stage_pipe.sv
// Registered RV32I decode stage: decode, operand forwarding, load-use stall and the ID/EX register.
// Optional: define ID_ILLEGAL_TRAP_EN to add the registered illegal_o flag.
module id_stage_pipe #(
    parameter int XLEN      = 32,
    parameter int RADDR_W   = 5,
    parameter int FWD_N     = 2,
    parameter int STALL_MAX = 15
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [31:0]              inst_i,
    input  logic [XLEN-1:0]          inst_addr_i,
    output logic [RADDR_W-1:0]       rs1_addr_o,
    output logic [RADDR_W-1:0]       rs2_addr_o,
    input  logic [XLEN-1:0]          rs1_data_i,
    input  logic [XLEN-1:0]          rs2_data_i,
    input  logic [FWD_N-1:0]         fwd_wen_i,
    input  logic [FWD_N-1:0]         fwd_is_load_i,
    input  logic [FWD_N*RADDR_W-1:0] fwd_addr_i,
    input  logic [FWD_N*XLEN-1:0]    fwd_data_i,
    input  logic                     flush_i,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [31:0]              inst_o,
    output logic [XLEN-1:0]          inst_addr_o,
    output logic [XLEN-1:0]          op1_o,
    output logic [XLEN-1:0]          op2_o,
    output logic [XLEN-1:0]          imm_o,
    output logic [RADDR_W-1:0]       rd_addr_o,
    output logic                     reg_wen_o,
    output logic                     mem_ren_o,
    output logic                     mem_wen_o,
    output logic [3:0]               stall_cnt_o
`ifdef ID_ILLEGAL_TRAP_EN
    ,
    output logic                     illegal_o
`endif
);

    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;

    typedef enum logic [1:0] {A_ZERO, A_RS, A_PC, A_IMM} op1_sel_t;
    typedef enum logic [1:0] {B_ZERO, B_RS, B_IMM, B_FOUR} op2_sel_t;

    function automatic logic [3:0] sat_inc(input logic [3:0] cnt);
        return (cnt >= 4'(STALL_MAX)) ? 4'(STALL_MAX) : cnt + 4'd1;
    endfunction

    // Lowest-index matching channel wins; result is {data_not_ready, value}.
    function automatic logic [XLEN:0] resolve(
        input logic [RADDR_W-1:0]       addr,
        input logic [XLEN-1:0]          rf,
        input logic [FWD_N-1:0]         wen,
        input logic [FWD_N-1:0]         is_load,
        input logic [FWD_N*RADDR_W-1:0] faddr,
        input logic [FWD_N*XLEN-1:0]    fdata
    );
        logic [XLEN:0] r;
        r = {1'b0, rf};
        for (int k = FWD_N - 1; k >= 0; k--)
            if (wen[k] && faddr[k*RADDR_W +: RADDR_W] == addr)
                r = {is_load[k], fdata[k*XLEN +: XLEN]};
        if (addr == '0)
            r = '0;
        return r;
    endfunction

    logic [6:0] opcode, funct7;
    logic [2:0] funct3;
    logic signed [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j, imm_sh;

    assign opcode = inst_i[6:0];
    assign funct3 = inst_i[14:12];
    assign funct7 = inst_i[31:25];
    assign imm_i  = XLEN'($signed(inst_i[31:20]));
    assign imm_s  = XLEN'($signed({inst_i[31:25], inst_i[11:7]}));
    assign imm_b  = XLEN'($signed({inst_i[31], inst_i[7], inst_i[30:25], inst_i[11:8], 1'b0}));
    assign imm_u  = XLEN'($signed({inst_i[31:12], 12'b0}));
    assign imm_j  = XLEN'($signed({inst_i[31], inst_i[19:12], inst_i[20], inst_i[30:21], 1'b0}));
    assign imm_sh = XLEN'(inst_i[24:20]);

    logic legal, use_rs1, use_rs2, has_rd, ren_p0, mwen_p0, store_imm;
    op1_sel_t op1_sel;
    op2_sel_t op2_sel;
    logic signed [XLEN-1:0] dec_imm;

    always_comb begin
        legal     = 1'b0;
        use_rs1   = 1'b0;
        use_rs2   = 1'b0;
        has_rd    = 1'b0;
        ren_p0    = 1'b0;
        mwen_p0   = 1'b0;
        store_imm = 1'b0;
        op1_sel   = A_ZERO;
        op2_sel   = B_ZERO;
        dec_imm   = '0;
        case (opcode)
            OPC_OPIMM: begin
                legal   = (funct3 == 3'b001) ? (funct7 == 7'h00) :
                          (funct3 == 3'b101) ? (funct7 == 7'h00 || funct7 == 7'h20) : 1'b1;
                use_rs1 = 1'b1;
                has_rd  = 1'b1;
                op1_sel = A_RS;
                op2_sel = B_IMM;
                dec_imm = (funct3[1:0] == 2'b01) ? imm_sh : imm_i;
            end
            OPC_OP: begin
                legal   = (funct7 == 7'h00) ||
                          (funct7 == 7'h20 && (funct3 == 3'b000 || funct3 == 3'b101));
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
                has_rd  = 1'b1;
                op1_sel = A_RS;
                op2_sel = B_RS;
            end
            OPC_BRANCH: begin
                legal   = (funct3[2:1] != 2'b01);
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
                op1_sel = A_RS;
                op2_sel = B_RS;
                dec_imm = imm_b;
            end
            OPC_JAL: begin
                legal   = 1'b1;
                has_rd  = 1'b1;
                op1_sel = A_PC;
                op2_sel = B_FOUR;
                dec_imm = imm_j;
            end
            OPC_JALR: begin
                legal   = (funct3 == 3'b000);
                use_rs1 = 1'b1;
                has_rd  = 1'b1;
                op1_sel = A_PC;
                op2_sel = B_FOUR;
                dec_imm = imm_i;
            end
            OPC_LUI: begin
                legal   = 1'b1;
                has_rd  = 1'b1;
                op1_sel = A_IMM;
                dec_imm = imm_u;
            end
            OPC_AUIPC: begin
                legal   = 1'b1;
                has_rd  = 1'b1;
                op1_sel = A_PC;
                op2_sel = B_IMM;
                dec_imm = imm_u;
            end
            OPC_LOAD: begin
                legal   = (funct3 != 3'b011) && (funct3[2:1] != 2'b11);
                use_rs1 = 1'b1;
                has_rd  = 1'b1;
                ren_p0  = 1'b1;
                op1_sel = A_RS;
                op2_sel = B_IMM;
                dec_imm = imm_i;
            end
            OPC_STORE: begin
                legal     = (funct3[2] == 1'b0) && (funct3[1:0] != 2'b11);
                use_rs1   = 1'b1;
                use_rs2   = 1'b1;
                mwen_p0   = 1'b1;
                store_imm = 1'b1;
                op1_sel   = A_RS;
                op2_sel   = B_IMM;
                dec_imm   = imm_s;
            end
            default: ;
        endcase
        // Anything outside the base set collapses to a NOP.
        if (!legal) begin
            use_rs1   = 1'b0;
            use_rs2   = 1'b0;
            has_rd    = 1'b0;
            ren_p0    = 1'b0;
            mwen_p0   = 1'b0;
            store_imm = 1'b0;
            op1_sel   = A_ZERO;
            op2_sel   = B_ZERO;
            dec_imm   = '0;
        end
    end

    logic [RADDR_W-1:0] rs1_addr, rs2_addr, rd_p0;
    logic wen_p0;

    assign rs1_addr   = use_rs1 ? RADDR_W'(inst_i[19:15]) : '0;
    assign rs2_addr   = use_rs2 ? RADDR_W'(inst_i[24:20]) : '0;
    assign rd_p0      = has_rd ? RADDR_W'(inst_i[11:7]) : '0;
    assign wen_p0     = has_rd && (rd_p0 != '0);
    assign rs1_addr_o = rs1_addr;
    assign rs2_addr_o = rs2_addr;

    logic rs1_ld, rs2_ld;
    logic signed [XLEN-1:0] rs1_val, rs2_val, op1_p0, op2_p0, imm_p0;

    assign {rs1_ld, rs1_val} = resolve(rs1_addr, rs1_data_i, fwd_wen_i, fwd_is_load_i, fwd_addr_i, fwd_data_i);
    assign {rs2_ld, rs2_val} = resolve(rs2_addr, rs2_data_i, fwd_wen_i, fwd_is_load_i, fwd_addr_i, fwd_data_i);

    always_comb begin
        case (op1_sel)
            A_RS:    op1_p0 = rs1_val;
            A_PC:    op1_p0 = inst_addr_i;
            A_IMM:   op1_p0 = dec_imm;
            default: op1_p0 = '0;
        endcase
        case (op2_sel)
            B_RS:    op2_p0 = rs2_val;
            B_IMM:   op2_p0 = dec_imm;
            B_FOUR:  op2_p0 = XLEN'(4);
            default: op2_p0 = '0;
        endcase
        imm_p0 = store_imm ? rs2_val : dec_imm;
    end

    logic vld_p1, hazard, load_en, take;

    assign hazard   = in_valid && (rs1_ld || rs2_ld);
    assign load_en  = out_ready || !vld_p1;
    assign in_ready = load_en && !hazard && !flush_i;
    assign take     = load_en && in_valid && !hazard;

    // ---- ID/EX register boundary ----
    logic [31:0] inst_p1;
    logic [XLEN-1:0] pc_p1;
    logic signed [XLEN-1:0] op1_p1, op2_p1, imm_p1;
    logic [RADDR_W-1:0] rd_p1;
    logic wen_p1, ren_p1, mwen_p1;
    logic [3:0] stall_p1;
`ifdef ID_ILLEGAL_TRAP_EN
    logic illegal_p1;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1   <= 1'b0;
            inst_p1  <= 32'h0000_0013;
            pc_p1    <= '0;
            op1_p1   <= '0;
            op2_p1   <= '0;
            imm_p1   <= '0;
            rd_p1    <= '0;
            wen_p1   <= 1'b0;
            ren_p1   <= 1'b0;
            mwen_p1  <= 1'b0;
            stall_p1 <= '0;
`ifdef ID_ILLEGAL_TRAP_EN
            illegal_p1 <= 1'b0;
`endif
        end else if (flush_i) begin
            vld_p1   <= 1'b0;
            stall_p1 <= '0;
        end else begin
            stall_p1 <= hazard ? sat_inc(stall_p1) : '0;
            if (load_en)
                vld_p1 <= in_valid && !hazard;
            if (take) begin
                inst_p1 <= inst_i;
                pc_p1   <= inst_addr_i;
                op1_p1  <= op1_p0;
                op2_p1  <= op2_p0;
                imm_p1  <= imm_p0;
                rd_p1   <= rd_p0;
                wen_p1  <= wen_p0;
                ren_p1  <= ren_p0;
                mwen_p1 <= mwen_p0;
`ifdef ID_ILLEGAL_TRAP_EN
                illegal_p1 <= !legal;
`endif
            end
        end
    end

    assign out_valid   = vld_p1;
    assign inst_o      = inst_p1;
    assign inst_addr_o = pc_p1;
    assign op1_o       = op1_p1;
    assign op2_o       = op2_p1;
    assign imm_o       = imm_p1;
    assign rd_addr_o   = rd_p1;
    assign reg_wen_o   = wen_p1;
    assign mem_ren_o   = ren_p1;
    assign mem_wen_o   = mwen_p1;
    assign stall_cnt_o = stall_p1;
`ifdef ID_ILLEGAL_TRAP_EN
    assign illegal_o   = illegal_p1;
`endif

endmodule

// File: tb/tb_id_stage_pipe.sv
// Bench for id_stage_pipe: directed scenarios plus randomized traffic against a decode/scoreboard model.
module tb_id_stage_pipe;
    localparam int XLEN = 32, RADDR_W = 5, FWD_N = 2, STALL_MAX = 15;

    logic clk = 1'b0;
    logic rst_n;
    logic in_valid, in_ready, flush, out_valid, out_ready;
    logic [31:0] inst, inst_o;
    logic [31:0] pc, inst_addr_o, rs1_data, rs2_data, op1_o, op2_o, imm_o;
    logic [4:0] rs1_addr, rs2_addr, rd_addr_o;
    logic [FWD_N-1:0] fwd_wen, fwd_is_load;
    logic [FWD_N*5-1:0] fwd_addr;
    logic [FWD_N*32-1:0] fwd_data;
    logic reg_wen_o, mem_ren_o, mem_wen_o;
    logic [3:0] stall_cnt;
`ifdef ID_ILLEGAL_TRAP_EN
    logic illegal;
`endif

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    id_stage_pipe #(.XLEN(XLEN), .RADDR_W(RADDR_W), .FWD_N(FWD_N), .STALL_MAX(STALL_MAX)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .inst_i(inst), .inst_addr_i(pc), .rs1_addr_o(rs1_addr), .rs2_addr_o(rs2_addr),
        .rs1_data_i(rs1_data), .rs2_data_i(rs2_data), .fwd_wen_i(fwd_wen),
        .fwd_is_load_i(fwd_is_load), .fwd_addr_i(fwd_addr), .fwd_data_i(fwd_data),
        .flush_i(flush), .out_valid(out_valid), .out_ready(out_ready), .inst_o(inst_o),
        .inst_addr_o(inst_addr_o), .op1_o(op1_o), .op2_o(op2_o), .imm_o(imm_o),
        .rd_addr_o(rd_addr_o), .reg_wen_o(reg_wen_o), .mem_ren_o(mem_ren_o),
        .mem_wen_o(mem_wen_o), .stall_cnt_o(stall_cnt)
`ifdef ID_ILLEGAL_TRAP_EN
        , .illegal_o(illegal)
`endif
    );

    typedef struct packed {
        logic [31:0] op1, op2, imm;
        logic [4:0]  rd, rs1, rs2;
        logic        wen, ren, mwen, hz;
    } exp_t;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        in_valid = 1'b0; out_ready = 1'b1; flush = 1'b0;
        inst = 32'h0000_0013; pc = '0; rs1_data = '0; rs2_data = '0;
        fwd_wen = '0; fwd_is_load = '0; fwd_addr = '0; fwd_data = '0;
    endtask

    task automatic set_ch(input int k, input logic wen, input logic ld,
                          input logic [4:0] a, input logic [31:0] d);
        fwd_wen[k] = wen; fwd_is_load[k] = ld;
        fwd_addr[k*5 +: 5] = a; fwd_data[k*32 +: 32] = d;
    endtask

    // Source value as seen by the instruction: x0 is zero, then the first (youngest) matching channel, else regfile.
    function automatic logic [32:0] src(input logic [4:0] a, input logic [31:0] rf);
        if (a == 5'd0) return 33'd0;
        for (int k = 0; k < FWD_N; k++)
            if (fwd_wen[k] && fwd_addr[k*5 +: 5] == a)
                return {fwd_is_load[k], fwd_data[k*32 +: 32]};
        return {1'b0, rf};
    endfunction

    function automatic exp_t predict(input logic [31:0] w, input logic [31:0] p,
                                     input logic [31:0] r1, input logic [31:0] r2);
        exp_t e;
        logic [32:0] s1, s2;
        logic [31:0] iimm, simm, bimm, uimm, jimm;
        iimm = {{20{w[31]}}, w[31:20]};
        simm = {{20{w[31]}}, w[31:25], w[11:7]};
        bimm = {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
        uimm = {w[31:12], 12'h000};
        jimm = {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
        s1 = src(w[19:15], r1);
        s2 = src(w[24:20], r2);
        e = '0;
        case (w[6:0])
            7'h13: begin e.rs1 = w[19:15]; e.rd = w[11:7]; e.op1 = s1[31:0];
                         e.imm = (w[13:12] == 2'b01) ? {27'd0, w[24:20]} : iimm; e.op2 = e.imm; end
            7'h33: begin e.rs1 = w[19:15]; e.rs2 = w[24:20]; e.rd = w[11:7];
                         e.op1 = s1[31:0]; e.op2 = s2[31:0]; end
            7'h63: begin e.rs1 = w[19:15]; e.rs2 = w[24:20]; e.op1 = s1[31:0];
                         e.op2 = s2[31:0]; e.imm = bimm; end
            7'h6f: begin e.rd = w[11:7]; e.op1 = p; e.op2 = 32'd4; e.imm = jimm; end
            7'h67: begin e.rs1 = w[19:15]; e.rd = w[11:7]; e.op1 = p; e.op2 = 32'd4; e.imm = iimm; end
            7'h37: begin e.rd = w[11:7]; e.op1 = uimm; e.imm = uimm; end
            7'h17: begin e.rd = w[11:7]; e.op1 = p; e.op2 = uimm; e.imm = uimm; end
            7'h03: begin e.rs1 = w[19:15]; e.rd = w[11:7]; e.op1 = s1[31:0];
                         e.op2 = iimm; e.imm = iimm; e.ren = 1'b1; end
            7'h23: begin e.rs1 = w[19:15]; e.rs2 = w[24:20]; e.op1 = s1[31:0];
                         e.op2 = simm; e.imm = s2[31:0]; e.mwen = 1'b1; end
            default: ;
        endcase
        e.wen = (e.rd != 5'd0);
        e.hz  = (e.rs1 != 5'd0 && s1[32]) || (e.rs2 != 5'd0 && s2[32]);
        return e;
    endfunction

    function automatic logic [31:0] gen_inst();
        logic [4:0] rd, a1, a2;
        logic [2:0] f3;
        logic [31:0] r;
        rd = 5'($urandom_range(0, 7)); a1 = 5'($urandom_range(0, 7)); a2 = 5'($urandom_range(0, 7));
        r = $urandom;
        f3 = 3'($urandom_range(0, 7));
        case ($urandom_range(0, 8))
            0: begin
                if (f3 == 3'd1) return {7'h00, r[24:20], a1, f3, rd, 7'h13};
                if (f3 == 3'd5) return {r[0] ? 7'h20 : 7'h00, r[24:20], a1, f3, rd, 7'h13};
                return {r[31:20], a1, f3, rd, 7'h13};
            end
            1: return {((f3 == 3'd0 || f3 == 3'd5) && r[0]) ? 7'h20 : 7'h00, a2, a1, f3, rd, 7'h33};
            2: begin
                f3 = 3'($urandom_range(0, 5));
                if (f3 >= 3'd2) f3 = f3 + 3'd2;
                return {r[31:25], a2, a1, f3, r[11:7], 7'h63};
            end
            3: return {r[31:12], rd, 7'h6f};
            4: return {r[31:20], a1, 3'd0, rd, 7'h67};
            5: return {r[31:12], rd, 7'h37};
            6: return {r[31:12], rd, 7'h17};
            7: begin
                f3 = 3'($urandom_range(0, 4));
                if (f3 >= 3'd3) f3 = f3 + 3'd1;
                return {r[31:20], a1, f3, rd, 7'h03};
            end
            default: return {r[31:25], a2, a1, 3'($urandom_range(0, 2)), r[11:7], 7'h23};
        endcase
    endfunction

    task automatic test_reset();
        idle();
        rst_n = 1'b0;
        #12;
        vectors++;
        if (out_valid !== 1'b0 || inst_o !== 32'h13 || stall_cnt !== 4'd0) begin
            miscompares++;
            $display("FAIL reset_ctrl: got vld=%b inst=%h stall=%0d, want 0/00000013/0", out_valid, inst_o, stall_cnt);
        end
        vectors++;
        if ({inst_addr_o, op1_o, op2_o, imm_o, rd_addr_o, reg_wen_o, mem_ren_o, mem_wen_o} !== '0) begin
            miscompares++;
            $display("FAIL reset_data: got pc=%h op1=%h op2=%h imm=%h rd=%0d en=%b%b%b, want all 0",
                     inst_addr_o, op1_o, op2_o, imm_o, rd_addr_o, reg_wen_o, mem_ren_o, mem_wen_o);
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_fwd_priority();
        idle();
        in_valid = 1'b1; inst = 32'h0030_8293; pc = 32'h100; rs1_data = 32'd10;
        set_ch(1, 1'b1, 1'b0, 5'd1, 32'd20);
        set_ch(0, 1'b1, 1'b0, 5'd1, 32'd30);
        #1;
        vectors++;
        if (rs1_addr !== 5'd1 || rs2_addr !== 5'd0 || in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL fwd_addr: got rs1=%0d rs2=%0d rdy=%b, want 1/0/1", rs1_addr, rs2_addr, in_ready);
        end
        tick();
        vectors++;
        if (out_valid !== 1'b1 || op1_o !== 32'd30 || op2_o !== 32'd3 || rd_addr_o !== 5'd5 || reg_wen_o !== 1'b1) begin
            miscompares++;
            $display("FAIL fwd_ch0: got vld=%b op1=%0d op2=%0d rd=%0d wen=%b, want 1/30/3/5/1",
                     out_valid, op1_o, op2_o, rd_addr_o, reg_wen_o);
        end
        fwd_wen[0] = 1'b0;
        tick();
        vectors++;
        if (op1_o !== 32'd20) begin
            miscompares++;
            $display("FAIL fwd_ch1: got op1=%0d, want 20", op1_o);
        end
        fwd_wen = '0;
        tick();
        vectors++;
        if (op1_o !== 32'd10) begin
            miscompares++;
            $display("FAIL fwd_regfile: got op1=%0d, want 10", op1_o);
        end
    endtask

    task automatic test_load_use();
        idle();
        in_valid = 1'b1; inst = 32'h0021_01B3; rs1_data = 32'd1; rs2_data = 32'd1;
        set_ch(0, 1'b1, 1'b1, 5'd2, 32'h55);
        for (int c = 1; c <= 2; c++) begin
            #1;
            vectors++;
            if (in_ready !== 1'b0) begin
                miscompares++;
                $display("FAIL load_use_rdy: cycle %0d got in_ready=%b, want 0", c, in_ready);
            end
            tick();
            vectors++;
            if (out_valid !== 1'b0 || stall_cnt !== 4'(c)) begin
                miscompares++;
                $display("FAIL load_use_bubble: cycle %0d got vld=%b stall=%0d, want 0/%0d", c, out_valid, stall_cnt, c);
            end
        end
        set_ch(0, 1'b1, 1'b0, 5'd2, 32'd7);
        #1;
        vectors++;
        if (in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL load_use_release: got in_ready=%b, want 1", in_ready);
        end
        tick();
        vectors++;
        if (out_valid !== 1'b1 || op1_o !== 32'd7 || op2_o !== 32'd7 || rd_addr_o !== 5'd3 || stall_cnt !== 4'd0) begin
            miscompares++;
            $display("FAIL load_use_issue: got vld=%b op1=%0d op2=%0d rd=%0d stall=%0d, want 1/7/7/3/0",
                     out_valid, op1_o, op2_o, rd_addr_o, stall_cnt);
        end
    endtask

    task automatic test_stall_sat();
        idle();
        in_valid = 1'b1; inst = 32'h0021_01B3;
        set_ch(1, 1'b1, 1'b1, 5'd2, 32'h0);
        for (int c = 1; c <= 17; c++) begin
            tick();
            if (c == 15 || c == 17) begin
                vectors++;
                if (stall_cnt !== 4'd15) begin
                    miscompares++;
                    $display("FAIL stall_sat: cycle %0d got stall=%0d, want 15", c, stall_cnt);
                end
            end
        end
        idle();
        tick();
        vectors++;
        if (stall_cnt !== 4'd0) begin
            miscompares++;
            $display("FAIL stall_clear: got stall=%0d, want 0", stall_cnt);
        end
    endtask

    task automatic test_backpressure();
        idle();
        in_valid = 1'b1; inst = 32'h0550_0313; pc = 32'h200;
        tick();
        out_ready = 1'b0; inst = 32'h1234_53B7; pc = 32'h204;
        for (int c = 0; c < 3; c++) begin
            #1;
            vectors++;
            if (in_ready !== 1'b0) begin
                miscompares++;
                $display("FAIL bp_rdy: cycle %0d got in_ready=%b, want 0", c, in_ready);
            end
            tick();
            vectors++;
            if (out_valid !== 1'b1 || inst_o !== 32'h0550_0313 || inst_addr_o !== 32'h200 || op2_o !== 32'h55 || rd_addr_o !== 5'd6) begin
                miscompares++;
                $display("FAIL bp_hold: cycle %0d got vld=%b inst=%h pc=%h op2=%h rd=%0d, want 1/05500313/200/55/6",
                         c, out_valid, inst_o, inst_addr_o, op2_o, rd_addr_o);
            end
        end
        out_ready = 1'b1;
        #1;
        vectors++;
        if (in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL bp_release: got in_ready=%b, want 1", in_ready);
        end
        tick();
        vectors++;
        if (inst_o !== 32'h1234_53B7 || op1_o !== 32'h1234_5000 || op2_o !== 32'h0 || rd_addr_o !== 5'd7) begin
            miscompares++;
            $display("FAIL bp_next: got inst=%h op1=%h op2=%h rd=%0d, want 123453b7/12345000/0/7",
                     inst_o, op1_o, op2_o, rd_addr_o);
        end
    endtask

    task automatic test_flush_hazard();
        idle();
        in_valid = 1'b1; inst = 32'h0550_0313;
        tick();
        out_ready = 1'b0; inst = 32'h0021_01B3;
        set_ch(0, 1'b1, 1'b1, 5'd2, 32'h0);
        tick();
        vectors++;
        if (out_valid !== 1'b1 || stall_cnt !== 4'd1) begin
            miscompares++;
            $display("FAIL flush_pre: got vld=%b stall=%0d, want 1/1", out_valid, stall_cnt);
        end
        flush = 1'b1;
        #1;
        vectors++;
        if (in_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL flush_rdy: got in_ready=%b, want 0", in_ready);
        end
        tick();
        vectors++;
        if (out_valid !== 1'b0 || stall_cnt !== 4'd0) begin
            miscompares++;
            $display("FAIL flush_kill: got vld=%b stall=%0d, want 0/0", out_valid, stall_cnt);
        end
        flush = 1'b0;
    endtask

    task automatic test_store_x0();
        idle();
        in_valid = 1'b1; inst = 32'h0002_2423; rs1_data = 32'h1000; rs2_data = 32'hDEAD;
        set_ch(0, 1'b1, 1'b0, 5'd0, 32'hFFFF);
        #1;
        vectors++;
        if (rs1_addr !== 5'd4 || rs2_addr !== 5'd0) begin
            miscompares++;
            $display("FAIL store_addr: got rs1=%0d rs2=%0d, want 4/0", rs1_addr, rs2_addr);
        end
        tick();
        vectors++;
        if (out_valid !== 1'b1 || imm_o !== 32'h0 || op2_o !== 32'd8 || op1_o !== 32'h1000 ||
            mem_wen_o !== 1'b1 || reg_wen_o !== 1'b0 || mem_ren_o !== 1'b0) begin
            miscompares++;
            $display("FAIL store_x0: got vld=%b imm=%h op2=%h op1=%h mwen=%b wen=%b ren=%b, want 1/0/8/1000/1/0/0",
                     out_valid, imm_o, op2_o, op1_o, mem_wen_o, reg_wen_o, mem_ren_o);
        end
    endtask

    task automatic test_illegal();
        logic [167:0] got;
        idle();
        in_valid = 1'b1; inst = 32'h0020_818B; pc = 32'h300; rs1_data = 32'h11; rs2_data = 32'h22;
        #1;
        vectors++;
        if (rs1_addr !== 5'd0 || rs2_addr !== 5'd0) begin
            miscompares++;
            $display("FAIL illegal_addr: got rs1=%0d rs2=%0d, want 0/0", rs1_addr, rs2_addr);
        end
        tick();
        got = {inst_o, inst_addr_o, op1_o, op2_o, imm_o, rd_addr_o, reg_wen_o, mem_ren_o, mem_wen_o};
        vectors++;
        if (out_valid !== 1'b1 || got !== {32'h0020_818B, 32'h300, 104'd0}) begin
            miscompares++;
            $display("FAIL illegal_nop: got vld=%b bundle=%h, want 1/%h", out_valid, got, {32'h0020_818B, 32'h300, 104'd0});
        end
`ifdef ID_ILLEGAL_TRAP_EN
        vectors++;
        if (illegal !== 1'b1) begin
            miscompares++;
            $display("FAIL illegal_flag: got %b, want 1", illegal);
        end
`endif
    endtask

    task automatic test_reset_midstream();
        idle();
        in_valid = 1'b1; inst = 32'h0550_0313; pc = 32'h400;
        tick();
        vectors++;
        if (out_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL midrst_pre: got vld=%b, want 1", out_valid);
        end
        #3 rst_n = 1'b0;
        #1;
        vectors++;
        if (out_valid !== 1'b0 || inst_o !== 32'h13 || op2_o !== 32'h0 || inst_addr_o !== 32'h0) begin
            miscompares++;
            $display("FAIL midrst: got vld=%b inst=%h op2=%h pc=%h, want 0/00000013/0/0", out_valid, inst_o, op2_o, inst_addr_o);
        end
        #2 rst_n = 1'b1;
        idle();
        tick();
    endtask

    task automatic test_random();
        exp_t e, me;
        logic m_vld, hz, len;
        logic [31:0] m_inst, m_pc;
        logic [3:0] st;
        logic [167:0] got, want;
        idle();
        rst_n = 1'b0;
        #2 rst_n = 1'b1;
        m_vld = 1'b0; st = 4'd0; me = '0; m_inst = 32'h13; m_pc = '0;
        for (int n = 0; n < 400; n++) begin
            in_valid  = ($urandom_range(0, 7) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            inst = gen_inst();
            pc = $urandom & 32'hFFFF_FFFC;
            rs1_data = $urandom; rs2_data = $urandom;
            for (int k = 0; k < FWD_N; k++)
                set_ch(k, 1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0),
                       5'($urandom_range(0, 7)), $urandom);
            #1;
            e = predict(inst, pc, rs1_data, rs2_data);
            hz = in_valid && e.hz;
            len = out_ready || !m_vld;
            vectors++;
            if (rs1_addr !== e.rs1 || rs2_addr !== e.rs2 || in_ready !== (len && !hz)) begin
                miscompares++;
                $display("FAIL rand_comb: n=%0d inst=%h got rs1=%0d rs2=%0d rdy=%b, want %0d/%0d/%b",
                         n, inst, rs1_addr, rs2_addr, in_ready, e.rs1, e.rs2, len && !hz);
            end
            tick();
            st = hz ? ((st == 4'(STALL_MAX)) ? st : st + 4'd1) : 4'd0;
            if (len) begin
                m_vld = in_valid && !hz;
                if (m_vld) begin me = e; m_inst = inst; m_pc = pc; end
            end
            vectors++;
            if (out_valid !== m_vld || stall_cnt !== st) begin
                miscompares++;
                $display("FAIL rand_ctrl: n=%0d got vld=%b stall=%0d, want %b/%0d", n, out_valid, stall_cnt, m_vld, st);
            end
            if (m_vld) begin
                got  = {inst_o, inst_addr_o, op1_o, op2_o, imm_o, rd_addr_o, reg_wen_o, mem_ren_o, mem_wen_o};
                want = {m_inst, m_pc, me.op1, me.op2, me.imm, me.rd, me.wen, me.ren, me.mwen};
                vectors++;
                if (got !== want) begin
                    miscompares++;
                    $display("FAIL rand_data: n=%0d got %h want %h", n, got, want);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_fwd_priority();
        test_load_use();
        test_stall_sat();
        test_backpressure();
        test_flush_hazard();
        test_store_x0();
        test_illegal();
        test_reset_midstream();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
